// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the sram_sync_port scratch memory:
//   - state_e      : controller states (clear sweep / normal operation)
//   - RD_LAT_MIN/MAX : the range of read latencies the port supports
//   - rd_lat_ok()  : legality test for a read latency value
//   - even_parity(): parity bit that makes the stored word + bit even
// -----------------------------------------------------------------------------
package sram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,  // clearing the array, requests refused
    ST_RUN  = 1'b1   // accepting one request per cycle
  } state_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  function automatic logic rd_lat_ok(input int unsigned lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

  // Callers zero-extend their word to 64 bits; the extra zeros do not
  // change the XOR reduction.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sram_array.sv
// -----------------------------------------------------------------------------
// sram_array
// Single-port storage array: synchronous write, registered read, no reset on
// the contents so it maps onto block RAM.
// Ports:
//   clk    in   clock, rising edge
//   we_i   in   write enable (word addr_i <- wdata_i at this edge)
//   re_i   in   read enable  (rdata_o <- word addr_i at this edge)
//   addr_i in   word index, IDX_W bits
//   wdata_i in  write data, WIDTH bits
//   rdata_o out registered read data, WIDTH bits
// -----------------------------------------------------------------------------
module sram_array #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write and read share one address; a write followed next cycle by a read
  // of the same word sees the new data because the write has already landed.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/sram_sync_port.sv
// -----------------------------------------------------------------------------
// sram_sync_port
// Parametrised single-port synchronous scratch SRAM with a valid/ready request
// channel, an in-order read-response channel and a hardware clear sweep that
// zeroes every word after each reset.
//
// Parameters: ADDR_W (address width), DATA_W (1..64), DEPTH (<= 2^ADDR_W),
//             RD_LAT (1 or 2 cycles from accepted read to rsp_valid).
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  high in RUN; request taken when req_valid && req_ready
//   req_we     in   1 = write, 0 = read
//   req_addr   in   word address, ADDR_W bits
//   req_wdata  in   write data, DATA_W bits
//   rsp_valid  out  one-cycle pulse per accepted read
//   rsp_rdata  out  read data (0 for out-of-range reads and when idle)
//   rsp_err    out  qualified by rsp_valid: out-of-range (or parity) error
//   init_done  out  high once the clear sweep has finished
//   inj_par_err in  (SRAM_PARITY_EN only) flips the stored parity on writes
//
// Build option: define SRAM_PARITY_EN to store an even-parity bit per word
// and flag mismatches on read through rsp_err.
// -----------------------------------------------------------------------------
module sram_sync_port
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 1 << ADDR_W,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
`ifdef SRAM_PARITY_EN
  ,
  input  logic              inj_par_err
`endif
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(DEPTH - 1);
  // An illegal latency falls back to the single-cycle path.
  localparam bit OUT_STAGE = rd_lat_ok(RD_LAT) && (RD_LAT == RD_LAT_MAX);

`ifdef SRAM_PARITY_EN
  localparam int unsigned ARR_W = DATA_W + 1;
`else
  localparam int unsigned ARR_W = DATA_W;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  logic                accept, rd_acc, in_range;
  logic                arr_we, arr_re;
  logic [IDX_W-1:0]    arr_addr;
  logic [ARR_W-1:0]    arr_wdata, arr_rdata;
  logic                s1_valid_q, s1_oob_q;
  logic                s1_err;
  logic [DATA_W-1:0]   s1_data;

  // ---------------------------------------------------------------------------
  // Controller FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == ST_INIT) && (sweep_q == SWEEP_LAST)) begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    req_ready = 1'b0;
    init_done = 1'b0;
    if (state_q == ST_RUN) begin
      req_ready = 1'b1;
      init_done = 1'b1;
    end
  end

  // Sweep counter walks 0..DEPTH-1 while clearing; it holds once in RUN.
  always_comb begin
    sweep_d = sweep_q;
    if (state_q == ST_INIT) begin
      sweep_d = sweep_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_q <= '0;
    end else begin
      sweep_q <= sweep_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Request decode and array port steering
  // ---------------------------------------------------------------------------
  assign accept   = req_valid && req_ready;
  assign rd_acc   = accept && !req_we;
  assign in_range = (32'(req_addr) < DEPTH);

  always_comb begin
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_addr  = req_addr[IDX_W-1:0];
    arr_wdata = '0;
    if (state_q == ST_INIT) begin
      // Clear sweep: data 0 and (with parity) a matching parity bit of 0.
      arr_we   = 1'b1;
      arr_addr = sweep_q[IDX_W-1:0];
    end else begin
      // Out-of-range requests never touch the array.
      arr_we = accept && req_we && in_range;
      arr_re = rd_acc && in_range;
`ifdef SRAM_PARITY_EN
      arr_wdata = {even_parity(64'(req_wdata)) ^ inj_par_err, req_wdata};
`else
      arr_wdata = req_wdata;
`endif
    end
  end

  sram_array #(
    .WIDTH (ARR_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  // ---------------------------------------------------------------------------
  // Response pipeline, stage 1: aligned with the array's registered read
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_oob_q   <= 1'b0;
    end else begin
      s1_valid_q <= rd_acc;
      s1_oob_q   <= rd_acc && !in_range;
    end
  end

  // The array's read register has no reset, so its data is only let through
  // for a valid in-range response; everything else reads as 0.
  always_comb begin
    s1_data = '0;
    s1_err  = 1'b0;
    if (s1_valid_q) begin
      if (s1_oob_q) begin
        s1_err = 1'b1;
      end else begin
        s1_data = arr_rdata[DATA_W-1:0];
`ifdef SRAM_PARITY_EN
        // Stored word plus parity bit must XOR to 0.
        s1_err = ^arr_rdata;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional output register for the two-cycle latency build
  // ---------------------------------------------------------------------------
  generate
    if (OUT_STAGE) begin : g_out_reg
      logic              rsp_valid_q;
      logic              rsp_err_q;
      logic [DATA_W-1:0] rsp_rdata_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end else begin
          rsp_valid_q <= s1_valid_q;
          rsp_err_q   <= s1_err;
          rsp_rdata_q <= s1_data;
        end
      end

      assign rsp_valid = rsp_valid_q;
      assign rsp_err   = rsp_err_q;
      assign rsp_rdata = rsp_rdata_q;
    end else begin : g_out_direct
      assign rsp_valid = s1_valid_q;
      assign rsp_err   = s1_err;
      assign rsp_rdata = s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_sram_sync_port.sv
// -----------------------------------------------------------------------------
// tb_sram_sync_port
// Drives two instances from one request stream:
//   A: ADDR_W=4, DEPTH=12, RD_LAT=1   (exercises out-of-range addresses 12..15)
//   B: ADDR_W=4, DEPTH=16, RD_LAT=2   (same requests, one extra cycle latency)
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_sram_sync_port;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       inj;

  logic       a_ready, a_valid, a_err, a_done;
  logic [7:0] a_rdata;
  logic       b_ready, b_valid, b_err, b_done;
  logic [7:0] b_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_sync_port #(.ADDR_W(4), .DATA_W(8), .DEPTH(12), .RD_LAT(1)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (a_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (a_valid),
    .rsp_rdata (a_rdata),
    .rsp_err   (a_err),
    .init_done (a_done)
`ifdef SRAM_PARITY_EN
    ,
    .inj_par_err (inj)
`endif
  );

  sram_sync_port #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .RD_LAT(2)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (b_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (b_valid),
    .rsp_rdata (b_rdata),
    .rsp_err   (b_err),
    .init_done (b_done)
`ifdef SRAM_PARITY_EN
    ,
    .inj_par_err (inj)
`endif
  );

  typedef struct {
    logic       v;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wd;
    logic       av;
    logic [7:0] ad;
    logic       ae;
    logic       bv;
    logic [7:0] bd;
    logic       be;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic we, input logic [3:0] addr,
                              input logic [7:0] wd, input logic av, input logic [7:0] ad,
                              input logic ae, input logic bv, input logic [7:0] bd,
                              input logic be);
    vec_t r;
    r.v = v; r.we = we; r.addr = addr; r.wd = wd;
    r.av = av; r.ad = ad; r.ae = ae;
    r.bv = bv; r.bd = bd; r.be = be;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic act_v, input logic [7:0] act_d,
                         input logic act_e, input logic exp_v, input logic [7:0] exp_d,
                         input logic exp_e);
    chk({tag, ".rsp_valid"}, 32'(act_v), 32'(exp_v));
    if (exp_v) begin
      chk({tag, ".rsp_rdata"}, 32'(act_d), 32'(exp_d));
      chk({tag, ".rsp_err"},   32'(act_e), 32'(exp_e));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
  endtask

  vec_t vecs[17];

  initial begin
    // v we addr wdata | A: v data err | B: v data err
    vecs[0]  = mk(1, 1,  0, 8'h05, 0, 8'h00, 0, 0, 8'h00, 0);
    vecs[1]  = mk(1, 1,  1, 8'h08, 0, 8'h00, 0, 0, 8'h00, 0);
    vecs[2]  = mk(1, 0,  0, 8'h00, 1, 8'h05, 0, 0, 8'h00, 0);
    vecs[3]  = mk(1, 0,  1, 8'h00, 1, 8'h08, 0, 1, 8'h05, 0);
    vecs[4]  = mk(0, 0,  0, 8'h00, 0, 8'h00, 0, 1, 8'h08, 0);
    vecs[5]  = mk(1, 1,  1, 8'h06, 0, 8'h00, 0, 0, 8'h00, 0);
    vecs[6]  = mk(1, 0,  1, 8'h00, 1, 8'h06, 0, 0, 8'h00, 0);
    vecs[7]  = mk(0, 0,  0, 8'h00, 0, 8'h00, 0, 1, 8'h06, 0);
    vecs[8]  = mk(1, 1, 13, 8'hAA, 0, 8'h00, 0, 0, 8'h00, 0);
    vecs[9]  = mk(1, 0, 13, 8'h00, 1, 8'h00, 1, 0, 8'h00, 0);
    vecs[10] = mk(1, 0,  0, 8'h00, 1, 8'h05, 0, 1, 8'hAA, 0);
    vecs[11] = mk(1, 0, 11, 8'h00, 1, 8'h00, 0, 1, 8'h05, 0);
    vecs[12] = mk(1, 0, 15, 8'h00, 1, 8'h00, 1, 1, 8'h00, 0);
    vecs[13] = mk(0, 0,  0, 8'h00, 0, 8'h00, 0, 1, 8'h00, 0);
    vecs[14] = mk(1, 1, 11, 8'h3C, 0, 8'h00, 0, 0, 8'h00, 0);
    vecs[15] = mk(1, 0, 11, 8'h00, 1, 8'h3C, 0, 0, 8'h00, 0);
    vecs[16] = mk(0, 0,  0, 8'h00, 0, 8'h00, 0, 1, 8'h3C, 0);

    rst_n     = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    inj       = 1'b0;
    idle();
    repeat (3) step();

    // Reset values
    chk("reset.a.req_ready", 32'(a_ready), 32'd0);
    chk("reset.a.rsp_valid", 32'(a_valid), 32'd0);
    chk("reset.a.rsp_rdata", 32'(a_rdata), 32'd0);
    chk("reset.a.rsp_err",   32'(a_err),   32'd0);
    chk("reset.a.init_done", 32'(a_done),  32'd0);
    chk("reset.b.req_ready", 32'(b_ready), 32'd0);
    chk("reset.b.rsp_valid", 32'(b_valid), 32'd0);
    chk("reset.b.rsp_rdata", 32'(b_rdata), 32'd0);
    chk("reset.b.init_done", 32'(b_done),  32'd0);

    // Clear sweep: ready/init_done rise after edge DEPTH following release.
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("sweep.a.req_ready@%0d", k), 32'(a_ready), 32'(k >= 12));
      chk($sformatf("sweep.a.init_done@%0d", k), 32'(a_done),  32'(k >= 12));
      chk($sformatf("sweep.b.req_ready@%0d", k), 32'(b_ready), 32'(k >= 16));
      chk($sformatf("sweep.b.init_done@%0d", k), 32'(b_done),  32'(k >= 16));
    end

    // Every address reads 0 after the sweep; A flags 12..15 out of range.
    for (int ad = 0; ad < 17; ad++) begin
      if (ad < 16) rd(4'(ad));
      else idle();
      step();
      chk_rsp($sformatf("cleared.a[%0d]", ad), a_valid, a_rdata, a_err,
              1'(ad < 16), 8'h00, 1'(ad >= 12 && ad < 16));
      chk_rsp($sformatf("cleared.b[%0d]", ad - 1), b_valid, b_rdata, b_err,
              1'(ad > 0), 8'h00, 1'b0);
    end

    // Table-driven request stream
    for (int i = 0; i < 17; i++) begin
      req_valid = vecs[i].v;
      req_we    = vecs[i].we;
      req_addr  = vecs[i].addr;
      req_wdata = vecs[i].wd;
      step();
      $display("[TB] vec %0d v=%0b we=%0b addr=%0d wdata=0x%02h | A %0b/0x%02h/%0b | B %0b/0x%02h/%0b",
               i, vecs[i].v, vecs[i].we, vecs[i].addr, vecs[i].wd,
               a_valid, a_rdata, a_err, b_valid, b_rdata, b_err);
      chk_rsp($sformatf("vec%0d.a", i), a_valid, a_rdata, a_err, vecs[i].av, vecs[i].ad, vecs[i].ae);
      chk_rsp($sformatf("vec%0d.b", i), b_valid, b_rdata, b_err, vecs[i].bv, vecs[i].bd, vecs[i].be);
    end

    // Reset with reads in flight
    rd(4'd0);
    step();
    rd(4'd1);
    step();
    rst_n = 1'b0;
    idle();
    #1;
    chk("midrst.a.rsp_valid", 32'(a_valid), 32'd0);
    chk("midrst.b.rsp_valid", 32'(b_valid), 32'd0);
    step();
    chk("midrst.a.rsp_valid+1", 32'(a_valid), 32'd0);
    chk("midrst.b.rsp_valid+1", 32'(b_valid), 32'd0);
    chk("midrst.a.req_ready",   32'(a_ready), 32'd0);
    step();
    rst_n = 1'b1;
    begin
      int waited;
      waited = 0;
      while (!(a_ready && b_ready) && waited < 40) begin
        step();
        waited++;
        chk($sformatf("reinit.no_rsp.a@%0d", waited), 32'(a_valid), 32'd0);
      end
      chk("reinit.ready", 32'(a_ready && b_ready), 32'd1);
    end
    rd(4'd0);
    step();
    chk_rsp("reinit.a[0]", a_valid, a_rdata, a_err, 1'b1, 8'h00, 1'b0);
    rd(4'd1);
    step();
    chk_rsp("reinit.a[1]", a_valid, a_rdata, a_err, 1'b1, 8'h00, 1'b0);
    chk_rsp("reinit.b[0]", b_valid, b_rdata, b_err, 1'b1, 8'h00, 1'b0);
    idle();
    step();
    chk_rsp("reinit.b[1]", b_valid, b_rdata, b_err, 1'b1, 8'h00, 1'b0);

`ifdef SRAM_PARITY_EN
    // Corrupted parity is reported, data passes through; clean rewrite clears it.
    wr(4'd3, 8'h7F);
    inj = 1'b1;
    step();
    inj = 1'b0;
    rd(4'd3);
    step();
    chk_rsp("par.bad.a", a_valid, a_rdata, a_err, 1'b1, 8'h7F, 1'b1);
    idle();
    step();
    chk_rsp("par.bad.b", b_valid, b_rdata, b_err, 1'b1, 8'h7F, 1'b1);
    wr(4'd3, 8'h7F);
    step();
    rd(4'd3);
    step();
    chk_rsp("par.ok.a", a_valid, a_rdata, a_err, 1'b1, 8'h7F, 1'b0);
    idle();
    step();
    chk_rsp("par.ok.b", b_valid, b_rdata, b_err, 1'b1, 8'h7F, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_sync_port.md
# sram_sync_port

Parametrised single-port synchronous SRAM with a valid/ready request channel, a pipelined read-response channel and hardware clear-on-reset. It replaces the fixed 8K×8 asynchronous RE/WE part with a bidirectional data bus: width, depth and read latency are configurable, and data paths are split into separate in and out buses. It sits behind bus masters as the local scratch memory.

## Interface
- ADDR_W, 13, address width
- DATA_W, 8, data word width (1..64)
- DEPTH, 1<<ADDR_W, number of implemented words (≤ 2^ADDR_W)
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  read data valid, one-cycle pulse per accepted read
- rsp_rdata  out  DATA_W  read data
- rsp_err  out  1  qualified by rsp_valid; read error
- init_done  out  1  high once clear sweep finished

## Operation
- States: INIT, RUN. Reset enters INIT with sweep counter = 0.
- INIT: req_ready=0; one word written to 0 per cycle, counter 0..DEPTH-1; after writing DEPTH-1, go to RUN, init_done=1.
- RUN: req_ready=1 every cycle; no backpressure on responses (consumer must always accept).
- Write accepted: word req_addr ← req_wdata at that edge; no response generated.
- Read accepted: response after RD_LAT cycles; reads issued back-to-back produce back-to-back responses, in order.
- Out-of-range (req_addr ≥ DEPTH): write dropped; read returns rsp_rdata=0, rsp_err=1.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data.
- Reset mid-operation: in-flight reads are discarded (rsp_valid=0 next cycle), state returns to INIT, and the array is re-cleared.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.

## Timing
- Clear sweep: init_done and req_ready rise DEPTH cycles after the first rising edge with rst_n=1.
- Read accepted in cycle N → rsp_valid high in cycle N+RD_LAT only.
- RD_LAT=2: output register stage after array read; data and err are both delayed.
- Throughput: one request per cycle in RUN.

## Configuration
- SRAM_PARITY_EN defined: array stores DATA_W+1 bits, with even parity generated on write. On read, a mismatch sets rsp_err=1 and passes data through unchanged. Sweep writes data 0 with parity 0. A hidden test port inj_par_err (in, 1) flips the stored parity bit on writes.
- Undefined: no parity storage and no inj_par_err port; rsp_err signals only out-of-range reads.

## Structure
- sram_pkg: state enum (INIT, RUN), RD_LAT legality constant, parity function.
- Sub-module sram_array: storage with synchronous write and registered read port, parametrised by width and depth. The top level holds the FSM, sweep counter, range check and latency pipeline.

## Test plan
- Reset release, DEPTH=16 → req_ready=0 for 16 cycles, then init_done=1; reading every address returns 0.
- Write addr 0=5, addr 1=8, then read 0, read 1 back-to-back (RD_LAT=1) → rsp 5, 8 on consecutive cycles.
- Write addr 1=6, then read addr 1 in the next cycle → 6; repeat with RD_LAT=2 → response two cycles after the read.
- DEPTH=12, ADDR_W=4: write addr 13=0xAA, then read addr 13 → rsp_rdata=0, rsp_err=1; addr 0..11 unchanged.
- Assert rst_n=0 with 2 reads in flight → no rsp_valid; after reset, prior data cleared to 0 once init_done rises.
- SRAM_PARITY_EN: write addr 3=0x7F with inj_par_err=1, read 3 → rsp_rdata=0x7F, rsp_err=1; clean rewrite → rsp_err=0.
